// File: rtl/pse_pkg.sv
// Shared types and helpers for the priority scan encoder.
package pse_pkg;

   typedef enum logic {
      PSE_IDLE = 1'b0,
      PSE_EMIT = 1'b1
   } pse_state_e;

   // Ceiling log2 used to size index outputs; callers guarantee n >= 2.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational highest-set-bit finder: idx is the top set index of in, any = |in.
module priority_encoder_n
   import pse_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Ascending scan so the highest set bit is the last to write idx.
   always_comb begin
      idx = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (in[i]) idx = IDX_W'(i);
      end
      any = |in;
   end

endmodule

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder: emits the index of each set request bit, highest first.
// Optional `last` output enabled by defining PSE_LAST_EN.
module priority_scan_encoder
   import pse_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] Y,
   output logic             V
`ifdef PSE_LAST_EN
   ,
   output logic             last
`endif
);

   pse_state_e       state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W-1:0] y_d;
   logic             any_d;

   // Next state and next pending set; Y/V are the registered view of pend_q.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         PSE_IDLE: begin
            if (in_valid) begin
               pend_d  = D;
               state_d = PSE_EMIT;
            end
         end
         PSE_EMIT: begin
            if (out_ready) begin
               pend_d = pend_q & ~(WIDTH'(1) << Y);
               if (!V || (pend_d == '0)) state_d = PSE_IDLE;
            end
         end
         default: state_d = PSE_IDLE;
      endcase
   end

   // Decode on the next pending set so Y/V/last land in the same cycle as pend_q.
   priority_encoder_n #(.WIDTH(WIDTH)) u_enc (
      .in  (pend_d),
      .idx (y_d),
      .any (any_d)
   );

`ifdef PSE_LAST_EN
   logic last_d;
   always_comb begin
      last_d = (state_d == PSE_EMIT) &&
               (!any_d || ((pend_d & (pend_d - WIDTH'(1))) == '0));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= PSE_IDLE;
         pend_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Y         <= '0;
         V         <= 1'b0;
`ifdef PSE_LAST_EN
         last      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         in_ready  <= (state_d == PSE_IDLE);
         out_valid <= (state_d == PSE_EMIT);
         Y         <= y_d;
         V         <= any_d;
`ifdef PSE_LAST_EN
         last      <= last_d;
`endif
      end
   end

endmodule
